// File: rtl/pc_stack_unit.sv
// Program-counter unit: instruction fetch address generation with increment,
// skip, jump, call/return through a circular return stack, and interrupt
// vectoring. Stack overflow/underflow are reported through sticky flags.
module pc_stack_unit #(
    parameter int unsigned PC_WIDTH     = 13,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned INT_VECTOR   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [PC_WIDTH-1:0]                target,
    input  logic                               clr_flags,
    output logic [PC_WIDTH-1:0]                out,
    output logic [PC_WIDTH-1:0]                tos,
    output logic [$clog2(STACK_DEPTH):0]       stack_depth,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = PTR_W + 1;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_SKIP = 3'd1;
    localparam logic [2:0] OP_JUMP = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_INT  = 3'd5;

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] INT_PC   = PC_WIDTH'(INT_VECTOR);
    localparam logic [DEPTH_W-1:0]  FULL_CNT = DEPTH_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    top_ptr;

    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] push_val;
    logic                do_push;
    logic                do_pop;
    logic                stack_full;
    logic                stack_empty;

    // Top of stack is the slot just below the write pointer (circular).
    always_comb begin
        top_ptr = wr_ptr - PTR_W'(1);
        tos     = stack_mem[top_ptr];
    end

    // Occupancy status used for saturation and flag detection.
    always_comb begin
        stack_full  = (stack_depth == FULL_CNT);
        stack_empty = (stack_depth == '0);
    end

    // Operation decode: next PC and stack push/pop requests.
    always_comb begin
        next_pc  = out;
        push_val = out;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (en) begin
            case (op)
                OP_INC:  next_pc = out + PC_WIDTH'(1);
                OP_SKIP: next_pc = out + PC_WIDTH'(2);
                OP_JUMP: next_pc = target;
                OP_CALL: begin
                    do_push  = 1'b1;
                    push_val = out + PC_WIDTH'(1);
                    next_pc  = target;
                end
                OP_RET: begin
                    do_pop  = 1'b1;
                    next_pc = tos;
                end
                OP_INT: begin
                    do_push  = 1'b1;
                    push_val = out;
                    next_pc  = INT_PC;
                end
                default: next_pc = out;
            endcase
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_PC;
        end else begin
            out <= next_pc;
        end
    end

    // Return-stack storage; a push writes the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_mem[PTR_W'(i)] <= '0;
            end
        end else if (do_push) begin
            stack_mem[wr_ptr] <= push_val;
        end
    end

    // Write pointer wraps freely; depth saturates at both ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            stack_depth <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!stack_full) begin
                stack_depth <= stack_depth + DEPTH_W'(1);
            end
        end else if (do_pop) begin
            wr_ptr <= top_ptr;
            if (!stack_empty) begin
                stack_depth <= stack_depth - DEPTH_W'(1);
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            stack_overflow  <= (stack_overflow  & ~clr_flags) | (do_push & stack_full);
            stack_underflow <= (stack_underflow & ~clr_flags) | (do_pop  & stack_empty);
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with hand-computed expected values.
module tb_pc_stack_unit;

    localparam int unsigned PW = 13;

    localparam logic [2:0] INC  = 3'd0;
    localparam logic [2:0] SKIP = 3'd1;
    localparam logic [2:0] JUMP = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;
    localparam logic [2:0] INTR = 3'd5;
    localparam logic [2:0] HOLD = 3'd6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [PW-1:0] target = '0;
    logic          clr_flags = 1'b0;
    logic [PW-1:0] out;
    logic [PW-1:0] tos;
    logic [3:0]    stack_depth;
    logic          stack_overflow;
    logic          stack_underflow;

    int vectors = 0;
    int errors  = 0;

    pc_stack_unit #(
        .PC_WIDTH(PW), .STACK_DEPTH(8), .RESET_VECTOR(0), .INT_VECTOR(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
        .clr_flags(clr_flags), .out(out), .tos(tos), .stack_depth(stack_depth),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then settle just past the rising edge.
    task automatic cyc(input logic r, input logic e, input logic [2:0] o,
                       input logic [PW-1:0] t, input logic c);
        reset = r; en = e; op = o; target = t; clr_flags = c;
        @(posedge clk);
        #1;
        reset = 1'b0; en = 1'b0; op = HOLD; clr_flags = 1'b0;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b0, HOLD, '0, 1'b0);
        vectors++; if (out !== 13'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", out); end
        vectors++; if (stack_depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", stack_depth); end
        vectors++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {stack_overflow, stack_underflow}); end
        vectors++; if (tos !== 13'h0000) begin errors++; $display("FAIL reset_tos: got %h want 0000", tos); end
    endtask

    task automatic test_inc_hold;
        logic [PW-1:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, INC, '0, 1'b0);
            exp_pc = PW'(i);
            vectors++; if (out !== exp_pc) begin errors++; $display("FAIL inc_%0d: got %h want %h", i, out, exp_pc); end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, INC, '0, 1'b0);
            vectors++; if (out !== 13'h0003) begin errors++; $display("FAIL en0_hold_%0d: got %h want 0003", i, out); end
        end
        cyc(1'b0, 1'b0, CALL, 13'h0555, 1'b0);
        vectors++; if (out !== 13'h0003 || stack_depth !== 4'd0) begin errors++; $display("FAIL en0_call: got out %h depth %0d want 0003 0", out, stack_depth); end
        cyc(1'b0, 1'b1, HOLD, 13'h0555, 1'b0);
        vectors++; if (out !== 13'h0003) begin errors++; $display("FAIL op_hold: got %h want 0003", out); end
        vectors++; if ({stack_overflow, stack_underflow, stack_depth} !== 6'b0) begin errors++; $display("FAIL inc_status: got %b want 000000", {stack_overflow, stack_underflow, stack_depth}); end
    endtask

    task automatic test_wrap;
        cyc(1'b0, 1'b1, JUMP, 13'h1FFF, 1'b0);
        vectors++; if (out !== 13'h1FFF) begin errors++; $display("FAIL jump_1fff: got %h want 1fff", out); end
        cyc(1'b0, 1'b1, INC, '0, 1'b0);
        vectors++; if (out !== 13'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", out); end
        cyc(1'b0, 1'b1, JUMP, 13'h1FFE, 1'b0);
        cyc(1'b0, 1'b1, SKIP, '0, 1'b0);
        vectors++; if (out !== 13'h0000) begin errors++; $display("FAIL skip_wrap0: got %h want 0000", out); end
        cyc(1'b0, 1'b1, JUMP, 13'h1FFF, 1'b0);
        cyc(1'b0, 1'b1, SKIP, '0, 1'b0);
        vectors++; if (out !== 13'h0001) begin errors++; $display("FAIL skip_wrap1: got %h want 0001", out); end
    endtask

    task automatic test_call_ret;
        cyc(1'b0, 1'b1, JUMP, 13'h0010, 1'b0);
        cyc(1'b0, 1'b1, CALL, 13'h0200, 1'b0);
        vectors++; if (out !== 13'h0200) begin errors++; $display("FAIL call_out: got %h want 0200", out); end
        vectors++; if (tos !== 13'h0011) begin errors++; $display("FAIL call_tos: got %h want 0011", tos); end
        vectors++; if (stack_depth !== 4'd1) begin errors++; $display("FAIL call_depth: got %0d want 1", stack_depth); end
        cyc(1'b0, 1'b1, RET, '0, 1'b0);
        vectors++; if (out !== 13'h0011) begin errors++; $display("FAIL ret_out: got %h want 0011", out); end
        vectors++; if ({stack_overflow, stack_underflow, stack_depth} !== 6'b0) begin errors++; $display("FAIL ret_status: got %b want 000000", {stack_overflow, stack_underflow, stack_depth}); end
    endtask

    task automatic test_overflow_underflow;
        logic [PW-1:0] exp_pc;
        logic [3:0]    exp_d;
        cyc(1'b1, 1'b0, HOLD, '0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            cyc(1'b0, 1'b1, CALL, PW'(13'h0100 + k), 1'b0);
            exp_pc = PW'(13'h0100 + k);
            vectors++; if (out !== exp_pc) begin errors++; $display("FAIL call9_out_%0d: got %h want %h", k, out, exp_pc); end
            vectors++; if (stack_overflow !== (k == 8)) begin errors++; $display("FAIL call9_ovf_%0d: got %b want %b", k, stack_overflow, (k == 8)); end
        end
        vectors++; if (stack_depth !== 4'd8) begin errors++; $display("FAIL ovf_depth: got %0d want 8", stack_depth); end
        vectors++; if (tos !== 13'h0108) begin errors++; $display("FAIL ovf_tos: got %h want 0108", tos); end
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, 1'b1, RET, '0, 1'b0);
            exp_pc = (j == 0) ? 13'h0108 : PW'(13'h0108 - j);
            exp_d  = 4'(7 - j);
            vectors++; if (out !== exp_pc || stack_depth !== exp_d) begin errors++; $display("FAIL ret8_%0d: got out %h depth %0d want %h %0d", j, out, stack_depth, exp_pc, exp_d); end
            vectors++; if (stack_underflow !== 1'b0) begin errors++; $display("FAIL ret8_unf_%0d: got %b want 0", j, stack_underflow); end
        end
        cyc(1'b0, 1'b1, RET, '0, 1'b0);
        vectors++; if (out !== 13'h0108) begin errors++; $display("FAIL unf_out: got %h want 0108", out); end
        vectors++; if (stack_underflow !== 1'b1 || stack_depth !== 4'd0) begin errors++; $display("FAIL unf_flag: got unf %b depth %0d want 1 0", stack_underflow, stack_depth); end
        cyc(1'b0, 1'b0, HOLD, '0, 1'b1);
        vectors++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL clr_flags: got %b want 00", {stack_overflow, stack_underflow}); end
        vectors++; if (out !== 13'h0108) begin errors++; $display("FAIL clr_out: got %h want 0108", out); end
        // Underflow event in the same cycle as a clear leaves the flag set.
        cyc(1'b0, 1'b1, RET, '0, 1'b1);
        vectors++; if (stack_underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_event: got %b want 1", stack_underflow); end
        vectors++; if (out !== 13'h0107) begin errors++; $display("FAIL clr_vs_event_out: got %h want 0107", out); end
        cyc(1'b0, 1'b0, HOLD, '0, 1'b1);
        vectors++; if (stack_underflow !== 1'b0) begin errors++; $display("FAIL clr_again: got %b want 0", stack_underflow); end
    endtask

    task automatic test_interrupt;
        cyc(1'b1, 1'b0, HOLD, '0, 1'b0);
        cyc(1'b0, 1'b1, JUMP, 13'h0042, 1'b0);
        cyc(1'b0, 1'b1, INTR, 13'h0777, 1'b0);
        vectors++; if (out !== 13'h0004) begin errors++; $display("FAIL int_out: got %h want 0004", out); end
        vectors++; if (tos !== 13'h0042 || stack_depth !== 4'd1) begin errors++; $display("FAIL int_stack: got tos %h depth %0d want 0042 1", tos, stack_depth); end
        cyc(1'b0, 1'b1, RET, '0, 1'b0);
        vectors++; if (out !== 13'h0042) begin errors++; $display("FAIL int_ret: got %h want 0042", out); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]    ops  [6] = '{CALL, RET, CALL, CALL, RET, RET};
        logic [PW-1:0] tgts [6] = '{13'h0050, 13'h0000, 13'h0060, 13'h0070, 13'h0000, 13'h0000};
        logic [PW-1:0] exps [6] = '{13'h0050, 13'h0001, 13'h0060, 13'h0070, 13'h0061, 13'h0002};
        cyc(1'b1, 1'b0, HOLD, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, ops[i], tgts[i], 1'b0);
            vectors++; if (out !== exps[i]) begin errors++; $display("FAIL b2b_%0d: got %h want %h", i, out, exps[i]); end
        end
        vectors++; if ({stack_overflow, stack_underflow, stack_depth} !== 6'b0) begin errors++; $display("FAIL b2b_status: got %b want 000000", {stack_overflow, stack_underflow, stack_depth}); end
    endtask

    task automatic test_reset_collision;
        cyc(1'b1, 1'b0, HOLD, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, CALL, PW'(13'h0020 + i), 1'b0);
        vectors++; if (stack_depth !== 4'd3) begin errors++; $display("FAIL pre_reset_depth: got %0d want 3", stack_depth); end
        cyc(1'b1, 1'b1, CALL, 13'h0300, 1'b0);
        vectors++; if (out !== 13'h0000 || stack_depth !== 4'd0) begin errors++; $display("FAIL rst_call: got out %h depth %0d want 0000 0", out, stack_depth); end
        vectors++; if ({stack_overflow, stack_underflow} !== 2'b00 || tos !== 13'h0000) begin errors++; $display("FAIL rst_call_flags_tos: got %b %h want 00 0000", {stack_overflow, stack_underflow}, tos); end
        cyc(1'b0, 1'b1, RET, '0, 1'b0);
        vectors++; if (out !== 13'h0000 || stack_underflow !== 1'b1) begin errors++; $display("FAIL rst_ret: got out %h unf %b want 0000 1", out, stack_underflow); end
    endtask

    initial begin
        test_reset();
        test_inc_hold();
        test_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_interrupt();
        test_back_to_back();
        test_reset_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the PIC16F887-style core simulation. It generates the instruction fetch address each cycle and supports sequential increment, skip, jump, call/return through a circular hardware return stack, and interrupt vectoring. Overflow and underflow are reported through sticky flags. It sits between the instruction decoder (which drives `op`/`target`) and program memory (which consumes `out`).

## Interface
- `PC_WIDTH`, 13: address width; all PC arithmetic is modulo 2^PC_WIDTH.
- `STACK_DEPTH`, 8: return-stack entries; must be a power of 2 and ≥ 2.
- `RESET_VECTOR`, 0: value loaded into `out` on reset.
- `INT_VECTOR`, 4: value loaded into `out` on interrupt entry.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset; has priority over all other inputs.
- `en`  in  1  advance enable; when 0, all state holds and `op` is ignored.
- `op`  in  3  operation select: 0 INC, 1 SKIP, 2 JUMP, 3 CALL, 4 RET, 5 INT, 6/7 HOLD.
- `target`  in  PC_WIDTH  destination address for JUMP and CALL.
- `clr_flags`  in  1  clears both sticky flags (synchronous).
- `out`  out  PC_WIDTH  current program counter (registered).
- `tos`  out  PC_WIDTH  entry at top of stack (slot ptr-1 mod DEPTH).
- `stack_depth`  out  $clog2(STACK_DEPTH)+1  valid entries, 0..STACK_DEPTH.
- `stack_overflow`  out  1  sticky; set by a push while depth = STACK_DEPTH.
- `stack_underflow`  out  1  sticky; set by a pop while depth = 0.

## Operation
- Reset sets `out`=RESET_VECTOR, write pointer=0, `stack_depth`=0, and both flags=0. All stack entries are cleared to 0.
- The following actions apply when `en`=1. Here `pc` is the current `out`.
  - INC: `out` ← pc+1.
  - SKIP: `out` ← pc+2.
  - JUMP: `out` ← `target`.
  - CALL: push pc+1, then `out` ← `target`.
  - RET: pop, then `out` ← popped value.
  - INT: push pc (the interrupted, not-yet-executed address), then `out` ← INT_VECTOR.
  - HOLD: no change.
- Push: write the value to slot ptr, then ptr ← ptr+1 mod DEPTH.
  - `stack_depth` increments, saturating at STACK_DEPTH.
  - When depth was already STACK_DEPTH, the oldest entry is overwritten and `stack_overflow` is set.
- Pop: ptr ← ptr-1 mod DEPTH, then read that slot.
  - `stack_depth` decrements, saturating at 0.
  - When depth was already 0, the read still occurs (circular, PIC-accurate) and `stack_underflow` is set.
- Flags stay set until `reset` or `clr_flags`. If `clr_flags` and a new overflow/underflow event occur in the same cycle, the flag ends up set.
- Stack operations never occur with `en`=0.

## Timing
- Latency is 1 cycle: `op` and `target` are sampled at edge N, and `out` reflects the result after edge N.
- There is no combinational path from `op`, `target` or `en` to any output. `tos` is a combinational read of the registered array and pointer only.
- Reset in the same cycle as any `op`: the reset values win, no push or pop occurs, and the flags are cleared.
- Wrap-around: pc = 2^PC_WIDTH-1 with INC gives 0. SKIP from 2^PC_WIDTH-2 gives 0, and from 2^PC_WIDTH-1 gives 1.
- Back-to-back CALL/RET are supported every cycle with no bubbles.

## Test plan
- Reset, then INC×3 with en=1 → `out` = 0, 1, 2, 3. Then en=0 for 2 cycles with op=INC → `out` stays 3. Flags 0 and depth 0 throughout.
- JUMP target=0x1FFF, then INC → `out`=0x0000. JUMP 0x1FFE, then SKIP → 0x0000. JUMP 0x1FFF, then SKIP → 0x0001.
- From `out`=0x0010, CALL target=0x0200 → `out`=0x0200, `tos`=0x0011, depth=1. Then RET → `out`=0x0011, depth=0, no flags.
- From reset, CALL nine times with target 0x100+k (k=0..8):
  - After the 9th CALL: depth=8, `stack_overflow`=1, `tos`=0x108.
  - Eight RETs then yield `out` = 0x108, 0x107, …, 0x101.
  - A 9th RET yields 0x108 with `stack_underflow`=1.
  - `clr_flags` then clears both flags.
- With `out`=0x0042, INT → `out`=0x0004, `tos`=0x0042, depth=1. Then RET → `out`=0x0042.
- Reset: assert `reset` in the same cycle as CALL target=0x0300 at depth 3 → `out`=0, depth=0, flags 0. A following RET → `out`=0 (cleared stack) and `stack_underflow`=1.
